// File: rtl/jpeg_pkg.sv
// Shared types for the JPEG front end: block geometry, pixel struct, tiler reader states.
package jpeg_pkg;
  localparam int BLK_DIM   = 8;
  localparam int PIX_W_DEF = 10;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] r;
    logic [PIX_W_DEF-1:0] g;
    logic [PIX_W_DEF-1:0] b;
  } rgb_pix_t;

  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;
endpackage

// File: rtl/tiler_strip_ram.sv
// Simple dual-port strip store: one write port, one registered read port with enable.
module tiler_strip_ram #(
  parameter int DW    = 30,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  // Read data holds when re_i is low; the skid logic relies on that.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/rgb_block_tiler.sv
// Raster RGB stream -> 8x8 block-order stream via two ping-pong 8-line strips.
// Optional RGB_BLOCK_TILER_OVF_CNT_EN adds a saturating dropped-pixel counter.
module rgb_block_tiler
  import jpeg_pkg::*;
#(
  parameter int IMG_WIDTH = 320,
  parameter int PIX_W     = 10
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             pix_valid_in,
  input  logic             sof_in,
  input  logic [PIX_W-1:0] r_in,
  input  logic [PIX_W-1:0] g_in,
  input  logic [PIX_W-1:0] b_in,
  output logic             blk_valid_out,
  input  logic             blk_ready_in,
  output logic [PIX_W-1:0] r_out,
  output logic [PIX_W-1:0] g_out,
  output logic [PIX_W-1:0] b_out,
  output logic [2:0]       row_out,
  output logic [2:0]       col_out,
  output logic             first_out,
  output logic             last_out,
`ifdef RGB_BLOCK_TILER_OVF_CNT_EN
  output logic [15:0]      ovf_count_out,
`endif
  output logic             ovf_out
);
  localparam int DW    = 3*PIX_W;
  localparam int STRIP = BLK_DIM*IMG_WIDTH;
  localparam int DEPTH = 2*STRIP;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = $clog2(IMG_WIDTH);
  localparam int NBX   = IMG_WIDTH/BLK_DIM;
  localparam int BXW   = $clog2(NBX);

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       first;
    logic       last;
    logic       eos;
  } meta_t;

  typedef struct packed {
    logic [DW-1:0] pix;
    meta_t         meta;
  } ent_t;

  // ---------------- writer ----------------
  logic [XW-1:0] x_q, wx;
  logic [2:0]    line_q, wl;
  logic          wb_q, ovf_q, wr_en, wr_drop, strip_done;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] wr_addr;

  always_comb begin
    wx         = sof_in ? '0 : x_q;
    wl         = sof_in ? '0 : line_q;
    wr_drop    = pix_valid_in & full_q[wb_q];
    wr_en      = pix_valid_in & ~full_q[wb_q];
    strip_done = wr_en && (wl == 3'd7) && (wx == XW'(IMG_WIDTH-1));
    wr_addr    = AW'(wb_q)*AW'(STRIP) + AW'(wl)*AW'(IMG_WIDTH) + AW'(wx);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      x_q    <= '0;
      line_q <= '0;
      wb_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_drop) ovf_q <= 1'b1;
      if (wr_en) begin
        if (wx == XW'(IMG_WIDTH-1)) begin
          x_q    <= '0;
          line_q <= wl + 3'd1;
        end else begin
          x_q    <= wx + XW'(1);
          line_q <= wl;
        end
        if (strip_done) wb_q <= ~wb_q;
      end
    end
  end

  assign ovf_out = ovf_q;

`ifdef RGB_BLOCK_TILER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;
  always_ff @(posedge clk_in) begin
    if (reset) ovf_cnt_q <= '0;
    else if (wr_drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end
  assign ovf_count_out = ovf_cnt_q;
`endif

  // ---------------- reader ----------------
  // Issue side (ib_q) runs ahead of the accept side (rb_q) so strips chain without bubbles;
  // a bank is only released once its final pixel has been accepted downstream.
  rd_state_t      st_q;
  logic           ib_q, rb_q, s_q, iss, room, pop, pop_f, push, blk_end, strip_end;
  logic [BXW-1:0] bx_q;
  logic [2:0]     rr_q, rc_q;
  meta_t          s_meta_q;
  ent_t [1:0]     f_q, f_d;
  logic [1:0]     cnt_q, cnt_d, wr_idx;
  ent_t           head, s_ent;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;

  always_comb begin
    s_ent         = '{pix: rd_data, meta: s_meta_q};
    head          = (cnt_q != 2'd0) ? f_q[0] : s_ent;
    blk_valid_out = (cnt_q != 2'd0) | s_q;
    pop           = blk_valid_out & blk_ready_in;
    // At most two pixels may be outstanding after this cycle's pop.
    room          = ({1'b0, cnt_q} + {2'b0, s_q}) <= ({2'b0, pop} + 3'd1);
    iss           = room & ((st_q == RD_DRAIN) | full_q[ib_q]);
    blk_end       = (rr_q == 3'd7) && (rc_q == 3'd7);
    strip_end     = blk_end && (bx_q == BXW'(NBX-1));
    rd_addr       = AW'(ib_q)*AW'(STRIP) + AW'(rr_q)*AW'(IMG_WIDTH)
                  + AW'(bx_q)*AW'(BLK_DIM) + AW'(rc_q);

    pop_f  = pop & (cnt_q != 2'd0);
    push   = s_q & ~(pop & (cnt_q == 2'd0));
    wr_idx = cnt_q - {1'b0, pop_f};
    f_d    = f_q;
    if (pop_f) f_d[0] = f_q[1];
    if (push) begin
      if (wr_idx == 2'd0) f_d[0] = s_ent;
      else                f_d[1] = s_ent;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop_f};

    full_d = full_q;
    if (strip_done)          full_d[wb_q] = 1'b1;
    if (pop && head.meta.eos) full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      st_q     <= RD_IDLE;
      ib_q     <= 1'b0;
      bx_q     <= '0;
      rr_q     <= '0;
      rc_q     <= '0;
      s_q      <= 1'b0;
      s_meta_q <= '0;
    end else begin
      s_q <= iss;
      if (iss) begin
        s_meta_q <= '{row: rr_q, col: rc_q, first: (rr_q == 3'd0 && rc_q == 3'd0),
                      last: blk_end, eos: strip_end};
        rc_q <= rc_q + 3'd1;
        if (rc_q == 3'd7) rr_q <= rr_q + 3'd1;
        if (blk_end) bx_q <= strip_end ? '0 : bx_q + BXW'(1);
        if (strip_end) begin
          ib_q <= ~ib_q;
          st_q <= full_q[~ib_q] ? RD_DRAIN : RD_IDLE;
        end else begin
          st_q <= RD_DRAIN;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      full_q <= 2'b00;
      rb_q   <= 1'b0;
      cnt_q  <= '0;
      f_q    <= '0;
    end else begin
      full_q <= full_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      if (pop && head.meta.eos) rb_q <= ~rb_q;
    end
  end

  always_comb begin
    {r_out, g_out, b_out} = blk_valid_out ? head.pix : '0;
    row_out   = blk_valid_out ? head.meta.row : 3'd0;
    col_out   = blk_valid_out ? head.meta.col : 3'd0;
    first_out = blk_valid_out & head.meta.first;
    last_out  = blk_valid_out & head.meta.last;
  end

  tiler_strip_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_in),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i ({r_in, g_in, b_in}),
    .re_i    (iss),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );
endmodule
